bist_resp_analyzer: RTL



---
 rtl/bist_resp_analyzer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: compacts CUT responses into a MISR and reports pass/fail at end of test.
// Optional macro BIST_FAIL_LOG_EN adds per-vector compare against exp_y and first-failure capture.
module bist_resp_analyzer #(
  parameter int                 PAT_W        = 2,
  parameter int                 DATA_W       = 4,
  parameter int                 NUM_PATTERNS = 16,
  parameter logic [DATA_W-1:0]  MISR_POLY    = 4'b0011,
  parameter logic [DATA_W-1:0]  MISR_SEED    = 4'b0000,
  parameter logic [DATA_W-1:0]  GOLDEN_SIG   = 4'hC,
  parameter int                 CNT_W        = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              testmode,
  input  logic              resp_valid,
  input  logic [PAT_W-1:0]  pat_a,
  input  logic [PAT_W-1:0]  pat_b,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] exp_y,
  output logic              busy,
  output logic              test_complete,
  output logic              test_good,
  output logic [DATA_W-1:0] signature,
  output logic              fail_valid,
  output logic [PAT_W-1:0]  fail_a,
  output logic [PAT_W-1:0]  fail_b,
  output logic [CNT_W-1:0]  fail_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] sig_q;
  logic [DATA_W-1:0] sig_next;
  logic              start;
  logic              accept;
  logic              last;

  assign start  = (state_q == S_IDLE) && testmode;
  assign accept = (state_q == S_RUN) && resp_valid;
  assign last   = accept && (count_q == CNT_W'(NUM_PATTERNS - 1));

  // Shift left, fold the MSB back through the polynomial taps, then mix in the response.
  assign sig_next = {sig_q[DATA_W-2:0], 1'b0}
                  ^ (sig_q[DATA_W-1] ? MISR_POLY : '0)
                  ^ y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An abort in RUN wins over reaching the final sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (testmode) state_d = S_RUN;
      S_RUN: begin
        if (!testmode)  state_d = S_IDLE;
        else if (last)  state_d = S_DONE;
      end
      S_DONE: if (!testmode) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q   <= MISR_SEED;
      count_q <= '0;
    end else if (start) begin
      sig_q   <= MISR_SEED;
      count_q <= '0;
    end else if (accept) begin
      sig_q   <= sig_next;
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign busy          = (state_q == S_RUN);
  assign test_complete = (state_q == S_DONE);
  assign signature     = sig_q;

`ifdef BIST_FAIL_LOG_EN
  logic             fail_valid_q;
  logic [PAT_W-1:0] fail_a_q;
  logic [PAT_W-1:0] fail_b_q;
  logic [CNT_W-1:0] fail_count_q;

  // Only the first mismatching vector is captured; the count keeps going and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_count_q <= '0;
    end else if (start) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_count_q <= '0;
    end else if (accept && (y != exp_y)) begin
      if (fail_count_q != '1) begin
        fail_count_q <= fail_count_q + CNT_W'(1);
      end
      if (!fail_valid_q) begin
        fail_valid_q <= 1'b1;
        fail_a_q     <= pat_a;
        fail_b_q     <= pat_b;
      end
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_count = fail_count_q;
  assign test_good  = test_complete && (sig_q == GOLDEN_SIG) && !fail_valid_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{exp_y, pat_a, pat_b};
  assign fail_valid    = 1'b0;
  assign fail_a        = '0;
  assign fail_b        = '0;
  assign fail_count    = '0;
  assign test_good     = test_complete && (sig_q == GOLDEN_SIG);
`endif

endmodule
